// File: rtl/des_cbc_stream.sv
// Byte-serial CBC-mode wrapper around a combinational DES core: packs plaintext bytes into
// 64-bit blocks, chains them with the previous ciphertext and streams the result out.
module des_cbc_stream #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        STOP,
    input  logic [63:0] IV,
    input  logic [63:0] KEY,
    input  logic [7:0]  IN_BYTE,
    input  logic        IN_VALID,
    output logic        IN_READY,
    output logic [7:0]  OUT_BYTE,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [63:0] DES_PT,
    output logic [63:0] DES_KEY,
    input  logic [63:0] DES_CT,
    output logic        BUSY
);

    typedef enum logic [1:0] {StIdle, StFill, StCrypt, StDrain} state_e;

    localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  settle_q, settle_d;
    logic [55:0] block_q, block_d;
    logic [63:0] chain_q, chain_d;
    logic [63:0] out_q, out_d;
    logic [63:0] pt_q, pt_d;
    logic [63:0] key_q, key_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic        busy_q, busy_d;

    logic        in_hs;
    logic        out_hs;
    logic [63:0] block_next;

    assign in_hs      = IN_VALID && in_ready_q;
    assign out_hs     = out_valid_q && OUT_READY;
    assign block_next = {block_q, IN_BYTE};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        settle_d = settle_q;
        block_d  = block_q;
        chain_d  = chain_q;
        out_d    = out_q;
        pt_d     = pt_q;
        key_d    = key_q;
        unique case (state_q)
            StIdle: begin
                if (START) begin
                    chain_d = IV;
                    key_d   = KEY;
                    cnt_d   = '0;
                    state_d = StFill;
                end
            end
            StFill: begin
                if (in_hs) begin
                    block_d = block_next[55:0];
                    if (cnt_q == 3'd7) begin
                        pt_d     = block_next ^ chain_q;
                        cnt_d    = '0;
                        settle_d = '0;
                        state_d  = StCrypt;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else if (STOP && cnt_q == 3'd0) begin
                    state_d = StIdle;
                end
            end
            StCrypt: begin
                // DES_PT has been stable for settle_d cycles when this edge samples DES_CT.
                settle_d = settle_q + 4'd1;
                if (settle_d == SettleLast) begin
                    out_d   = DES_CT;
                    chain_d = DES_CT;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (out_hs) begin
                    out_d = {out_q[55:0], 8'h00};
                    if (cnt_q == 3'd7) begin
                        cnt_d   = '0;
                        state_d = StFill;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        in_ready_d  = (state_d == StFill);
        out_valid_d = (state_d == StDrain);
        busy_d      = (state_d != StIdle);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            settle_q    <= '0;
            block_q     <= '0;
            chain_q     <= '0;
            out_q       <= '0;
            pt_q        <= '0;
            key_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            settle_q    <= settle_d;
            block_q     <= block_d;
            chain_q     <= chain_d;
            out_q       <= out_d;
            pt_q        <= pt_d;
            key_q       <= key_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_q;
    assign BUSY      = busy_q;
    assign OUT_BYTE  = out_q[63:56];
    assign DES_PT    = pt_q;
    assign DES_KEY   = key_q;

endmodule

// File: tb/tb_des_cbc_stream.sv
// Bench for des_cbc_stream: three instances (settle 2, 1, 15) run the same directed message
// sequence against a block-level CBC model and a stub core that is only valid once settled.
module tb_des_cbc_stream;

    localparam logic [63:0] KatKey = 64'h1334_5779_9BBC_DFF1;
    localparam logic [63:0] KatPt  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] KatCt  = 64'h85E8_1354_0F0A_B405;
    localparam logic [63:0] Blk2   = 64'h84CB_5633_86A1_79EA;
    localparam logic [63:0] Blk3   = 64'h1122_3344_5566_7788;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input int lane_id, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL lane%0d %s: got %h expected %h", lane_id, name, act, exp);
        end
    endtask

    // Stub DES core: the known-answer pair is exact, anything else is a keyed scramble.
    function automatic logic [63:0] core(input logic [63:0] pt, input logic [63:0] k);
        if (pt == KatPt && k == KatKey) return KatCt;
        return {pt[31:0] ^ k[63:32], pt[63:32] ^ k[31:0]} ^ 64'h5A5A_C3C3_0F0F_9696;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int S = (g == 0) ? 2 : ((g == 1) ? 1 : 15);

        logic        rst = 1'b1;
        logic        start = 1'b0;
        logic        stop = 1'b0;
        logic [63:0] iv = '0;
        logic [63:0] key = '0;
        logic [7:0]  in_byte = '0;
        logic        in_valid = 1'b0;
        logic        out_ready = 1'b1;
        logic        in_ready, out_valid, busy;
        logic [7:0]  out_byte;
        logic [63:0] des_pt, des_key, des_ct;

        int          cyc = 0;
        int          age = 0;
        int          pc = 0;
        logic [63:0] last_pt = '0;
        bit          done_l = 1'b0;
        bit          bp = 1'b0;

        bit          active = 1'b0;
        int          fill_m = 0;
        logic [63:0] blk_m = '0;
        logic [63:0] chain_m = '0;
        logic [63:0] key_m = '0;
        logic [7:0]  exp_bytes[$];
        logic [63:0] exp_pt[$];
        int          exp_edge[$];
        logic [63:0] got_blk = '0;

        logic        prev_valid = 1'b0;
        logic        prev_ready = 1'b0;
        logic [7:0]  prev_byte = '0;

        des_cbc_stream #(.SETTLE_CYCLES(S)) dut (
            .CLK       (clk),
            .RST       (rst),
            .START     (start),
            .STOP      (stop),
            .IV        (iv),
            .KEY       (key),
            .IN_BYTE   (in_byte),
            .IN_VALID  (in_valid),
            .IN_READY  (in_ready),
            .OUT_BYTE  (out_byte),
            .OUT_VALID (out_valid),
            .OUT_READY (out_ready),
            .DES_PT    (des_pt),
            .DES_KEY   (des_key),
            .DES_CT    (des_ct),
            .BUSY      (busy)
        );

        // age = edges since DES_PT last changed; the core output is garbage until settled.
        assign des_ct = (age >= S - 1) ? core(des_pt, des_key) : 64'hBAD0_BAD0_BAD0_BAD0;

        always @(posedge clk) begin
            cyc++;
            #1;
            if (des_pt !== last_pt) age = 0;
            else if (age < 1000) age++;
            last_pt = des_pt;
        end

        initial begin
            forever begin
                @(posedge clk);
                #1;
                pc++;
                out_ready = bp ? ((pc % 4 == 0) || (pc % 4 == 3)) : 1'b1;
            end
        end

        always @(negedge clk) begin
            if (rst) begin
                prev_valid = 1'b0;
                prev_ready = 1'b0;
            end else begin
                chk(g, "busy", busy, active);
                chk(g, "in_ready", in_ready, active && exp_bytes.size() == 0);
                if (prev_valid && !prev_ready) begin
                    chk(g, "stall_valid", out_valid, 1'b1);
                    chk(g, "stall_byte", out_byte, prev_byte);
                end
                if (out_valid && !prev_valid) begin
                    chk(g, "block_expected", exp_pt.size() > 0, 1'b1);
                    if (exp_pt.size() > 0) begin
                        chk(g, "des_pt", des_pt, exp_pt.pop_front());
                        chk(g, "des_key", des_key, key_m);
                        chk(g, "ct_latency", cyc - exp_edge.pop_front(), S);
                    end
                end
                if (out_valid && out_ready) begin
                    chk(g, "byte_expected", exp_bytes.size() > 0, 1'b1);
                    if (exp_bytes.size() > 0) chk(g, "out_byte", out_byte, exp_bytes.pop_front());
                    got_blk = {got_blk[55:0], out_byte};
                end
                prev_valid = out_valid;
                prev_ready = out_ready;
                prev_byte  = out_byte;
            end
        end

        task automatic send_byte(input logic [7:0] b, input bit gap);
            int n = 0;
            if (gap) begin
                @(posedge clk);
                #1;
            end
            in_byte  = b;
            in_valid = 1'b1;
            @(negedge clk);
            while (!in_ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk(g, "in_ready_wait", in_ready, 1'b1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (n < 200) begin
                blk_m = {blk_m[55:0], b};
                fill_m++;
                if (fill_m == 8) begin
                    logic [63:0] pt;
                    logic [63:0] ct;
                    pt      = blk_m ^ chain_m;
                    ct      = core(pt, key_m);
                    chain_m = ct;
                    fill_m  = 0;
                    exp_pt.push_back(pt);
                    exp_edge.push_back(cyc);
                    for (int i = 0; i < 8; i++) exp_bytes.push_back(ct[63 - 8 * i -: 8]);
                end
            end
        endtask

        task automatic send_block(input logic [63:0] blk, input bit gap);
            for (int i = 0; i < 8; i++) send_byte(blk[63 - 8 * i -: 8], gap && (i % 2 == 1));
        endtask

        task automatic do_start(input logic [63:0] v_iv, input logic [63:0] v_key);
            start = 1'b1;
            iv    = v_iv;
            key   = v_key;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (!active) begin
                active  = 1'b1;
                chain_m = v_iv;
                key_m   = v_key;
                fill_m  = 0;
            end
        endtask

        task automatic do_stop();
            stop = 1'b1;
            @(posedge clk);
            #1;
            stop = 1'b0;
            if (active && fill_m == 0) active = 1'b0;
        endtask

        task automatic do_reset();
            rst      = 1'b1;
            in_valid = 1'b0;
            start    = 1'b0;
            stop     = 1'b0;
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
            rst     = 1'b0;
            active  = 1'b0;
            fill_m  = 0;
            chain_m = '0;
            key_m   = '0;
            exp_bytes.delete();
            exp_pt.delete();
            exp_edge.delete();
            chk(g, "rst_in_ready", in_ready, 1'b0);
            chk(g, "rst_out_valid", out_valid, 1'b0);
            chk(g, "rst_busy", busy, 1'b0);
            chk(g, "rst_out_byte", out_byte, 8'h00);
            chk(g, "rst_des_pt", des_pt, 64'h0);
            chk(g, "rst_des_key", des_key, 64'h0);
        endtask

        task automatic wait_drain();
            int n = 0;
            while (exp_bytes.size() > 0 && n < 400) begin
                @(negedge clk);
                n++;
            end
            chk(g, "drain_done", exp_bytes.size(), 0);
            @(posedge clk);
            #1;
        endtask

        initial begin
            @(posedge clk);
            #1;
            do_reset();

            do_start(64'h0, KatKey);
            send_block(KatPt, 1'b0);
            wait_drain();
            chk(g, "kat_ct", got_blk, KatCt);
            chk(g, "kat_pt_held", des_pt, KatPt);

            // Chained block with input gaps, output backpressure and an ignored START.
            bp = 1'b1;
            for (int i = 0; i < 8; i++) begin
                if (i == 2) do_start(64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
                send_byte(Blk2[63 - 8 * i -: 8], (i % 2 == 1));
            end
            wait_drain();
            bp = 1'b0;
            chk(g, "chain_ct", got_blk, KatCt);
            chk(g, "chain_pt", des_pt, KatPt);
            chk(g, "key_kept", des_key, KatKey);

            for (int i = 0; i < 3; i++) send_byte(Blk3[63 - 8 * i -: 8], 1'b0);
            do_stop();
            chk(g, "stop_mid_busy", busy, 1'b1);
            for (int i = 3; i < 8; i++) send_byte(Blk3[63 - 8 * i -: 8], 1'b0);
            wait_drain();

            do_stop();
            chk(g, "stop_idle_busy", busy, 1'b0);
            chk(g, "stop_idle_in_ready", in_ready, 1'b0);

            do_start(64'h0F1E_2D3C_4B5A_6978, 64'hFEDC_BA98_7654_3210);
            for (int i = 0; i < 3; i++) send_byte(8'hFF, 1'b0);
            do_reset();
            do_start(64'h0, KatKey);
            send_block(KatPt, 1'b0);
            wait_drain();
            chk(g, "fresh_ct", got_blk, KatCt);
            do_stop();
            done_l = 1'b1;
        end
    end

    initial begin
        int n = 0;
        while (!(lane[0].done_l && lane[1].done_l && lane[2].done_l) && n < 20000) begin
            @(posedge clk);
            n++;
        end
        chk(3, "sequence_done", lane[0].done_l && lane[1].done_l && lane[2].done_l, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
